// File: rtl/div_unit_if.sv
// Handshake and result bundle between the control FSM (master) and the divider (slave).
// Operands and start travel to the divider; results and status pulses come back.
interface div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic             is_unsigned;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, is_unsigned, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, is_unsigned, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/div_unit.sv
// Multicycle signed restoring divider (DIV: quotient->lo, remainder->hi); DIVU behind `DIV_UNSIGNED_EN.
// Latency: done pulses 33 clocks after the start edge; div_zero pulses 1 clock after start.
// Backpressure: none; start is ignored while busy, so the caller must wait for done/div_zero.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    div_unit_if.slave   dif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem, quo, dvs;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             sign_q, sign_r;
    logic             busy_q, done_q, dz_q;

    logic             uns;
    logic             start_ok;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted;
    logic             trial_ok;
    logic [WIDTH-1:0] rem_nxt;

`ifdef DIV_UNSIGNED_EN
    assign uns = dif.is_unsigned;
`else
    assign uns = 1'b0;
`endif

    assign start_ok = dif.start && (dif.b != '0);
    assign mag_a    = (!uns && dif.a[WIDTH-1]) ? -dif.a : dif.a;
    assign mag_b    = (!uns && dif.b[WIDTH-1]) ? -dif.b : dif.b;

    // Shifted remainder can reach WIDTH+1 bits for unsigned divisors near 2^WIDTH;
    // when the trial succeeds the true difference always fits back into WIDTH bits.
    assign shifted  = {rem, quo[WIDTH-1]};
    assign trial_ok = shifted >= {1'b0, dvs};
    assign rem_nxt  = trial_ok ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = CALC;
            CALC:    if (count == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (dif.start && (dif.b == '0)) begin
                        dz_q <= 1'b1;
                    end else if (start_ok) begin
                        quo    <= mag_a;
                        dvs    <= mag_b;
                        sign_q <= !uns && (dif.a[WIDTH-1] ^ dif.b[WIDTH-1]);
                        sign_r <= !uns && dif.a[WIDTH-1];
                        rem    <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CALC: begin
                    rem   <= rem_nxt;
                    quo   <= {quo[WIDTH-2:0], trial_ok};
                    count <= count + 1'b1;
                end
                FIX: begin
                    lo_q   <= sign_q ? -quo : quo;
                    hi_q   <= sign_r ? -rem : rem;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign dif.hi       = hi_q;
    assign dif.lo       = lo_q;
    assign dif.busy     = busy_q;
    assign dif.done     = done_q;
    assign dif.div_zero = dz_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized bench for div_unit against a plain-arithmetic reference.
module tb_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef DIV_UNSIGNED_EN
    localparam bit UNS_EN = 1'b1;
`else
    localparam bit UNS_EN = 1'b0;
`endif

    div_unit_if #(.WIDTH(32)) dif ();

    div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // MIPS semantics: truncate toward zero, remainder follows dividend; 64-bit math
    // keeps 0x80000000 / -1 well defined (2^31 wraps to 0x80000000).
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic u,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (u) begin
            q = a / b;
            r = a % b;
            return;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic u, input string tag);
        logic [31:0] eq, er;
        int n;
        model(a, b, u && UNS_EN, eq, er);
        dif.a = a; dif.b = b; dif.is_unsigned = u; dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        check({tag, "_busy_after_start"}, {31'd0, dif.busy}, 32'd1);
        n = 0;
        while (!dif.done && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 32'd33);
        check({tag, "_busy_at_done"}, {31'd0, dif.busy}, 32'd0);
        check({tag, "_lo"}, dif.lo, eq);
        check({tag, "_hi"}, dif.hi, er);
    endtask

    initial begin
        int n, pulses;
        logic [31:0] ra, rb;
        logic        ru;

        reset = 1'b1;
        dif.start = 1'b0; dif.is_unsigned = 1'b0; dif.a = '0; dif.b = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_hi",   dif.hi, 32'd0);
        check("rst_lo",   dif.lo, 32'd0);
        check("rst_busy", {31'd0, dif.busy}, 32'd0);
        check("rst_done", {31'd0, dif.done}, 32'd0);
        check("rst_dz",   {31'd0, dif.div_zero}, 32'd0);

        do_div(32'd7, 32'd2, 1'b0, "pos");
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0, "negdvd");
        do_div(32'd7, 32'hFFFF_FFFE, 1'b0, "negdvs");

        // Divide by zero leaves the previous result untouched.
        do_div(32'd7, 32'd2, 1'b0, "preload");
        dif.a = 32'd5; dif.b = 32'd0; dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        check("dz_pulse", {31'd0, dif.div_zero}, 32'd1);
        check("dz_busy",  {31'd0, dif.busy}, 32'd0);
        tick();
        check("dz_one_cycle", {31'd0, dif.div_zero}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (dif.done || dif.busy) pulses++;
            tick();
        end
        check("dz_no_activity", pulses, 32'd0);
        check("dz_hi_kept", dif.hi, 32'd1);
        check("dz_lo_kept", dif.lo, 32'd3);

        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "ovf");

        // Reset mid-operation aborts without a completion.
        dif.a = 32'd100; dif.b = 32'd7; dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {31'd0, dif.busy}, 32'd0);
        check("abort_hi",   dif.hi, 32'd0);
        check("abort_lo",   dif.lo, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (dif.done) pulses++;
            tick();
        end
        check("abort_no_done", pulses, 32'd0);
        do_div(32'd100, 32'd7, 1'b0, "reissue");

        // A second start while busy must not disturb the running op.
        dif.a = 32'd9; dif.b = 32'd4; dif.is_unsigned = 1'b0; dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        dif.a = 32'd1; dif.b = 32'd1; dif.start = 1'b1;
        tick();
        dif.start = 1'b0;
        n = 5;
        while (!dif.done && n < 40) begin
            tick();
            n++;
        end
        check("ign_latency", n, 32'd33);
        check("ign_lo", dif.lo, 32'd2);
        check("ign_hi", dif.hi, 32'd1);

        do_div(32'hFFFF_FFFF, 32'd2, 1'b1, "uns");
        check("uns_lo_fixed", dif.lo, UNS_EN ? 32'h7FFF_FFFF : 32'd0);
        check("uns_hi_fixed", dif.hi, UNS_EN ? 32'd1 : 32'hFFFF_FFFF);

        for (int k = 0; k < 24; k++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'($urandom_range(1, 20));
                1:       rb = -32'($urandom_range(1, 20));
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            if (rb == 32'd0) rb = 32'd3;
            ru = 1'($urandom_range(0, 1));
            do_div(ra, rb, ru, $sformatf("rnd%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider, one restoring iteration per clock.
- Executes DIV: quotient to LO, remainder to HI.
- Its hi/lo outputs drive the HI and LO inputs of the register write-data mux.
- The control FSM starts it with a one-cycle start pulse and waits on done or div_zero.

Parameters:
- WIDTH, 32, operand/result width; iteration counter width is clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; operands sampled on the same edge
- is_unsigned  input  1  DIVU select; functional only with DIV_UNSIGNED_EN
- a  input  WIDTH  dividend (rs)
- b  input  WIDTH  divisor (rt)
- hi  output  WIDTH  remainder register
- lo  output  WIDTH  quotient register
- busy  output  1  registered; high while an operation is in flight
- done  output  1  registered one-cycle pulse; hi/lo updated
- div_zero  output  1  registered one-cycle pulse; divisor was zero

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0; counter and datapath regs cleared.
  - Reset mid-operation aborts it; no done is issued for the aborted op.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - done and div_zero default to 0 each cycle (pulse outputs).
  - Edge E0 with start=1 and b==0: div_zero<=1 for one cycle; hi/lo unchanged; stay in IDLE; busy stays 0.
  - Edge E0 with start=1 and b!=0:
    - latch |a| and |b| as unsigned magnitudes;
    - latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB];
    - clear the partial remainder; count=0; busy<=1; go to CALC.
- CALC: one restoring step per edge, E1..E32:
  - shift {rem, dividend} left 1;
  - trial = rem - divisor, computed WIDTH+1 bits wide;
  - if trial is non-negative: rem=trial and the quotient bit is 1; else rem is kept and the quotient bit is 0;
  - count increments each step; on the edge where count==WIDTH-1, go to FIX.
- FIX, edge E33:
  - lo <= sign_q ? -quotient : quotient;
  - hi <= sign_r ? -rem : rem;
  - done<=1, busy<=0, return to IDLE.
- Latency:
  - done is high in the cycle after E33, i.e. 33 clocks after start is sampled;
  - new hi/lo are visible in that same cycle and hold until the next completion or reset.
- start while busy=1 is ignored, and the operands are not resampled.
- Sign rules (MIPS):
  - quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives magnitude 0x80000000 / 1. Required result: lo=0x80000000, hi=0. No overflow flag.
- Magnitude/negate arithmetic is unsigned WIDTH-bit; |0x80000000| = 0x80000000 is taken as unsigned.
- hi/lo are never written by a div_zero or aborted operation.

Optional Feature:
- Macro: DIV_UNSIGNED_EN.
- Defined:
  - when start=1 and is_unsigned=1, operands are taken as-is (no magnitude conversion);
  - sign_q=0 and sign_r=0, so no sign fix in FIX;
  - timing is identical;
  - div_zero applies to unsigned ops as well.
- Not defined: is_unsigned is ignored and every operation is signed; the port still exists so the top-level wiring is unchanged.

Test Plan:
- a=7, b=2, start 1 cycle -> busy high next cycle; done exactly 33 clocks after the start edge; lo=3, hi=1; busy=0 with done.
- a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- Preload hi=1/lo=3, then a=5, b=0 -> div_zero=1 for exactly one cycle; busy=0 throughout; no done; hi=1, lo=3 unchanged.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0 after 33 clocks.
- Start a=100, b=7; assert reset at clock 10 -> next edge busy=0, hi=lo=0, and done never pulses; re-issue a=100, b=7 -> lo=14, hi=2.
- Start a=9, b=4, then pulse start again with a=1, b=1 at clock 5 -> second start ignored; result lo=2, hi=1.
- Unsigned select, a=0xFFFFFFFF, b=2, is_unsigned=1:
  - with DIV_UNSIGNED_EN: lo=0x7FFFFFFF, hi=1;
  - without DIV_UNSIGNED_EN: lo=0, hi=0xFFFFFFFF.
